// File: rtl/bsk_com_filter.sv
//==============================================================================
// Module   : bsk_com_filter
// Purpose  : Input conditioning for the PRD board command lines. Raw,
//            active-low, asynchronous optocoupler inputs are synchronised to
//            clk, then each channel is debounced by a sampled
//            consecutive-count filter. Produces the clean active-high command
//            word, a one-clk change strobe and a sticky per-channel change
//            mask that the host clears with an acknowledge.
// Ports    : clk          - system clock (2 MHz)
//            aclr         - asynchronous active-high reset
//            iRawCom      - raw command inputs, active low, asynchronous
//            iAck         - one-clk acknowledge, clears oChangeMask
//            oCom         - filtered commands, active high
//            oStrobe      - one-clk pulse after any oCom update
//            oChangeMask  - sticky per-channel change flags since last iAck
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsk_com_filter #(
    parameter int WIDTH      = 16,
    parameter int SAMPLE_DIV = 20,
    parameter int FILT_CNT   = 8
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [WIDTH-1:0] iRawCom,
    input  logic             iAck,
    output logic [WIDTH-1:0] oCom,
    output logic             oStrobe,
    output logic [WIDTH-1:0] oChangeMask
);

    // Guard against zero-width counters for degenerate parameter choices.
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [DIV_W-1:0] div_cnt;
    logic             sample_edge;
    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] new_chg;

    // Two-flop synchroniser. Resetting to all-ones makes every channel read
    // as inactive straight out of reset, so no spurious edge is filtered in.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= iRawCom;
            s2 <= s1;
        end
    end

    // Free-running sample divider; the sample edge is the edge at which the
    // counter reads zero before it reloads.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            div_cnt <= DIV_LOAD;
        end else if (div_cnt == '0) begin
            div_cnt <= DIV_LOAD;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign sample_edge = (div_cnt == '0);
    assign lvl         = ~s2;

    // Per-channel consecutive-count filter. Any sample that agrees with the
    // current output clears the count, so short glitches cannot accumulate
    // across gaps, and rising and falling transitions are treated alike.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CNT_W-1:0] cnt;
        logic             com_q;

        assign new_chg[i] = sample_edge && (lvl[i] != com_q) && (cnt == CNT_LAST);
        assign oCom[i]    = com_q;

        always_ff @(posedge clk or posedge aclr) begin
            if (aclr) begin
                cnt   <= '0;
                com_q <= 1'b0;
            end else if (sample_edge) begin
                if (lvl[i] == com_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    com_q <= lvl[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Change reporting. A bit newly changed on the same edge as an ack stays
    // set: the ack only clears what the host has already seen.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            oStrobe     <= 1'b0;
            oChangeMask <= '0;
        end else begin
            oStrobe     <= |new_chg;
            oChangeMask <= (iAck ? '0 : oChangeMask) | new_chg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bsk_com_filter.sv
//==============================================================================
// Module   : tb_bsk_com_filter
// Purpose  : Self-checking bench for bsk_com_filter. Expected oCom updates
//            (edge number, value, change mask) are queued when stimulus is
//            driven and compared when the DUT raises oStrobe.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bsk_com_filter;

    localparam int W  = 16;
    localparam int SD = 20;
    localparam int FC = 8;

    logic         clk     = 1'b0;
    logic         aclr    = 1'b1;
    logic [W-1:0] iRawCom = '1;
    logic         iAck    = 1'b0;
    logic [W-1:0] oCom;
    logic         oStrobe;
    logic [W-1:0] oChangeMask;

    bsk_com_filter #(
        .WIDTH      (W),
        .SAMPLE_DIV (SD),
        .FILT_CNT   (FC)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .iRawCom     (iRawCom),
        .iAck        (iAck),
        .oCom        (oCom),
        .oStrobe     (oStrobe),
        .oChangeMask (oChangeMask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           at_edge;
        logic [W-1:0] com;
        logic [W-1:0] mask;
    } exp_t;

    typedef struct {
        logic         ack;
        logic [W-1:0] raw;
        logic [W-1:0] com;
        logic [W-1:0] mask;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[7];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int strobes  = 0;
    int e_race;
    int strobes_before;

    // Rising edges since the last reset release (edge 1 is the first).
    always @(posedge clk or posedge aclr) begin
        if (aclr) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Edge at which oCom updates for a raw change applied just before edge n:
    // s2 carries it from edge n+1, so the first sample that sees it is the
    // first multiple of SD at or after n+2; FC-1 further samples complete it.
    function automatic int chg_edge(input int n);
        return ((n + 2 + SD - 1) / SD) * SD + (FC - 1) * SD;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!aclr && oStrobe) begin
            strobes++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe at edge %0d oCom=%h expected none",
                         edge_cnt, oCom);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_edge", edge_cnt, mon_e.at_edge);
                check("strobe_com", 32'(oCom), 32'(mon_e.com));
                check("strobe_mask", 32'(oChangeMask), 32'(mon_e.mask));
            end
        end
    end

    task automatic drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending updates expected 0 (next due edge %0d)",
                     sb.size(), sb[0].at_edge);
            sb.delete();
        end
    endtask

    task automatic wait_to(input int e);
        int g;
        g = 0;
        while (edge_cnt < e && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("wait_edge", edge_cnt, e);
    endtask

    task automatic do_reset(input logic [W-1:0] raw);
        @(negedge clk);
        aclr    = 1'b1;
        iAck    = 1'b0;
        iRawCom = raw;
        sb.delete();
        @(negedge clk);
        check("rst_com", 32'(oCom), 32'h0);
        check("rst_strobe", 32'(oStrobe), 32'h0);
        check("rst_mask", 32'(oChangeMask), 32'h0);
        aclr = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        iAck = 1'b1;
        @(negedge clk);
        iAck = 1'b0;
    endtask

    task automatic apply_raw(input logic [W-1:0] raw, input logic [W-1:0] ecom,
                             input logic [W-1:0] emask);
        @(negedge clk);
        iRawCom = raw;
        sb.push_back('{chg_edge(edge_cnt + 1), ecom, emask});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 16'h0000, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF};
        tbl[2] = '{1'b1, 16'h7FFE, 16'h8001, 16'h8001};
        tbl[3] = '{1'b0, 16'h7FFF, 16'h8000, 16'h8001};
        tbl[4] = '{1'b1, 16'hA5A5, 16'h5A5A, 16'hDA5A};
        tbl[5] = '{1'b0, 16'h5A5A, 16'hA5A5, 16'hFFFF};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h0000, 16'hA5A5};

        // Reset with all inputs active: all channels assert together at 160.
        do_reset(16'h0000);
        sb.push_back('{chg_edge(1), 16'hFFFF, 16'hFFFF});
        wait_to(159);
        check("pre160_com", 32'(oCom), 32'h0);
        drain(60);
        check("all_on_com", 32'(oCom), 32'hFFFF);

        // Single channel 3 from reset, then release it for 200 clk.
        do_reset(16'hFFF7);
        sb.push_back('{chg_edge(1), 16'h0008, 16'h0008});
        drain(200);
        apply_raw(16'hFFFF, 16'h0000, 16'h0008);
        repeat (200) @(negedge clk);
        check("ch3_off_com", 32'(oCom), 32'h0);
        check("ch3_off_mask", 32'(oChangeMask), 32'h0008);
        drain(1);

        // Table of steady-state transitions, 300 clk per phase.
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].ack) pulse_ack();
            apply_raw(tbl[i].raw, tbl[i].com, tbl[i].mask);
            drain(300);
            repeat (5) @(negedge clk);
            check("tbl_com", 32'(oCom), 32'(tbl[i].com));
            check("tbl_mask", 32'(oChangeMask), 32'(tbl[i].mask));
        end

        // Glitch rejection on channel 5: 130 clk low spans at most 7 samples.
        pulse_ack();
        strobes_before = strobes;
        for (int r = 0; r < 10; r++) begin
            @(negedge clk);
            iRawCom = 16'hFFDF;
            repeat (130) @(negedge clk);
            iRawCom = 16'hFFFF;
            repeat (40) @(negedge clk);
        end
        check("glitch_com", 32'(oCom), 32'h0);
        check("glitch_strobes", strobes - strobes_before, 0);
        check("glitch_mask", 32'(oChangeMask), 32'h0);

        // Ack race: channel 1 change coincides with iAck.
        apply_raw(16'hFFFE, 16'h0001, 16'h0001);
        drain(200);
        @(negedge clk);
        iRawCom = 16'hFFFC;
        e_race  = chg_edge(edge_cnt + 1);
        sb.push_back('{e_race, 16'h0003, 16'h0002});
        wait_to(e_race - 1);
        iAck = 1'b1;
        @(negedge clk);
        iAck = 1'b0;
        drain(5);
        check("race_mask", 32'(oChangeMask), 32'h0002);
        pulse_ack();
        check("ack_clear_mask", 32'(oChangeMask), 32'h0);

        // Reset in the middle of a filter count on channel 7.
        do_reset(16'hFF7F);
        wait_to(149);
        aclr = 1'b1;
        @(negedge clk);
        check("midrst_com", 32'(oCom), 32'h0);
        aclr = 1'b0;
        sb.push_back('{chg_edge(1), 16'h0080, 16'h0080});
        wait_to(159);
        check("midrst_pre_com", 32'(oCom), 32'h0);
        drain(60);
        check("midrst_com_final", 32'(oCom), 32'h0080);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
